load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface: accepts one load or store request at a time from the core datapath and drives the word-organised data memory's address, enables and write data. It performs RV32I sub-word handling: byte/halfword lane extraction with sign/zero extension on loads, and read-modify-write merging on SB/SH, because the memory only writes whole words. It sits between the core's execute stage and the data memory, and stalls the core via `busy` while a transaction is in flight.

## Interface
- `ADDR_W`, 32, width of the request and memory address.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  1  request strobe; accepted only when `busy`=0.
- `is_store`  input  1  1 = store, 0 = load.
- `funct3`  input  3  RV32I width code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- `addr`  input  ADDR_W  byte address.
- `store_data`  input  32  store operand; low bits are used for SB/SH.
- `busy`  output  1  high while the FSM is not IDLE.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  valid with `done`: misaligned address or illegal funct3.
- `load_data`  output  32  extended load result; held until the next load completes.
- `mem_addr`  output  ADDR_W  word-aligned address, `{addr_q[ADDR_W-1:2],2'b00}`.
- `mem_wdata`  output  32  write word.
- `mem_read_en`  output  1  read enable.
- `mem_write_en`  output  1  write enable; the memory commits on the rising edge.
- `mem_rdata`  input  32  combinational read data from the memory.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE**, on `req`: capture `is_store`, `funct3`, `addr` and `store_data` into `*_q` registers. Then:
  - if `err_cond` is true → DONE with `err` set;
  - else LW/LB/LH/LBU/LHU → READ;
  - else SW → WRITE;
  - else SB/SH → READ.
- `err_cond`:
  - load with funct3 ∈ {3,6,7};
  - store with funct3 > 2;
  - H/HU/SH with `addr[0]`=1;
  - W with `addr[1:0]`≠0.
  - An error issues no memory access.
- **READ**: `mem_read_en`=1. At the clock edge, latch `mem_rdata` into `rword_q`. A load then goes → DONE; SB/SH goes → WRITE.
- **WRITE**: `mem_write_en`=1 → DONE.
  - SW: `mem_wdata` = `store_data_q`.
  - SB: `rword_q` with byte lane `addr_q[1:0]` replaced by `store_data_q[7:0]`.
  - SH: `rword_q` with halfword lane `addr_q[1]` replaced by `store_data_q[15:0]`.
  - Lanes are little-endian: lane 0 = bits [7:0].
- **DONE**: `done`=1 for exactly one cycle → IDLE.
  - For a successful load, `load_data` is updated on entry to DONE (registered).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - A store or an error leaves `load_data` unchanged.
- `err` is registered. It is high only during DONE of an errored request, and 0 otherwise.
- `busy` = (state ≠ IDLE). A `req` while busy is ignored; there is no queueing.
- Outputs are decoded only from state and `*_q` registers. There is no combinational path from core inputs to memory outputs.
- `mem_wdata` = 0 outside WRITE. `mem_read_en` and `mem_write_en` are never high together.

## Timing
- Reset (asynchronous, `reset`=0):
  - state = IDLE;
  - `busy`, `done`, `err`, `mem_read_en`, `mem_write_en` = 0;
  - `load_data`, `mem_wdata`, `mem_addr`, `rword_q` = 0.
  - Reset during READ or WRITE aborts the transaction immediately. No write is committed if reset asserts before the WRITE-cycle edge.
- Latency from the accepting edge (edge 0) to `done` high:
  - load: 2 cycles (READ, DONE);
  - SW: 2 cycles (WRITE, DONE);
  - SB/SH: 3 cycles (READ, WRITE, DONE);
  - error: 1 cycle.
- `busy` rises the cycle after acceptance and falls with `done`. A new `req` can be accepted in the cycle after DONE, i.e. while IDLE.
- A `req` presented in the DONE cycle is ignored.
- `mem_addr` is stable for the whole transaction.

## Test plan
- **Reset:** hold `reset`=0 with `req`=1 → all outputs 0, no enables; release → stays IDLE until `req`.
- **SW then LW:** SW addr=0x10, data=0xDEADBEEF → one cycle with `mem_write_en`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF, `done` 2 cycles after acceptance. Then LW 0x10 → `load_data`=0xDEADBEEF, `err`=0.
- **SB merge:** word 0x11223344 at 0x8; SB addr=0xA, data=0xFF → READ then WRITE with `mem_wdata`=0x11FF3344, `done` at cycle 3. Then LB 0xA → 0xFFFFFFFF; LBU 0xA → 0x000000FF.
- **SH/LH:** SH addr=0xE, data=0x8001 onto 0xAAAAAAAA at 0xC → write 0x8001AAAA. LH 0xE → 0xFFFF8001; LHU 0xE → 0x00008001.
- **Errors:** LW 0x6, SH 0x3 and load funct3=3 → `done`+`err` 1 cycle after acceptance, `mem_read_en`/`mem_write_en` never asserted, `load_data` unchanged.
- **Busy / abort:** `req` pulses during busy → ignored, exactly one `done`. SB with `reset` asserted during READ → no `mem_write_en`, memory word unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-organised data memory,
// sub-word load extraction and read-modify-write merging for SB/SH.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_is_store;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_store_data;
    logic [31:0]         r_rword;
    logic [31:0]         r_load_data;
    logic                r_err;
    logic                w_err_cond;
    logic [31:0]         w_lane;
    logic [31:0]         w_load_ext;
    logic [31:0]         w_merge;

    always_comb begin
        w_err_cond = 1'b0;
        if (is_store)
            w_err_cond = (funct3 > 3'd2);
        else
            w_err_cond = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        if (((funct3 == 3'd1) || (funct3 == 3'd5)) && addr[0])
            w_err_cond = 1'b1;
        if ((funct3 == 3'd2) && (addr[1:0] != 2'b00))
            w_err_cond = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_err_cond)
                        w_next = S_DONE;
                    else if (is_store && (funct3 == 3'd2))
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:  w_next = r_is_store ? S_WRITE : S_DONE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane shifted down to bit 0, then extended according to the width code.
    always_comb begin
        w_lane     = mem_rdata >> {r_addr[1:0], 3'b000};
        w_load_ext = mem_rdata;
        case (r_funct3)
            3'd0:    w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'd1:    w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'd4:    w_load_ext = {24'd0, w_lane[7:0]};
            3'd5:    w_load_ext = {16'd0, w_lane[15:0]};
            default: w_load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = r_rword;
        case (r_funct3)
            3'd0: begin
                case (r_addr[1:0])
                    2'd0:    w_merge[7:0]   = r_store_data[7:0];
                    2'd1:    w_merge[15:8]  = r_store_data[7:0];
                    2'd2:    w_merge[23:16] = r_store_data[7:0];
                    default: w_merge[31:24] = r_store_data[7:0];
                endcase
            end
            3'd1: begin
                if (r_addr[1])
                    w_merge[31:16] = r_store_data[15:0];
                else
                    w_merge[15:0]  = r_store_data[15:0];
            end
            default: w_merge = r_store_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_is_store   <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_rword      <= '0;
            r_load_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            // Error flag is only ever set on the edge that moves IDLE straight to DONE.
            r_err   <= (r_state == S_IDLE) && req && w_err_cond;
            if ((r_state == S_IDLE) && req) begin
                r_is_store   <= is_store;
                r_funct3     <= funct3;
                r_addr       <= addr;
                r_store_data <= store_data;
            end
            if (r_state == S_READ) begin
                r_rword <= mem_rdata;
                if (!r_is_store)
                    r_load_data <= w_load_ext;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign err          = r_err;
    assign load_data    = r_load_data;
    assign mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_read_en  = (r_state == S_READ);
    assign mem_write_en = (r_state == S_WRITE);
    assign mem_wdata    = (r_state == S_WRITE) ? w_merge : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a word-array memory and a
// behavioural model of RV32I load/store semantics.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .is_store     (is_store),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .load_data    (load_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    logic [31:0] mem [0:15];
    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_write_en)
            mem[mem_addr[5:2]] <= mem_wdata;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] ref_mem [0:15];
    logic [31:0] ref_ld;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (st && f3 > 3'd2) return 1'b1;
        if (!st && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (a[1:0] * 8)) & 32'hFF;
        h = (w >> (a[1] * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                                input logic [31:0] a, input logic [31:0] d);
        int unsigned sh;
        case (f3)
            3'd0: begin
                sh = a[1:0] * 8;
                return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            end
            3'd1: begin
                sh = a[1] * 16;
                return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
            end
            default: return d;
        endcase
    endfunction

    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic noisy);
        logic        e;
        int          lat;
        int          reads;
        int          writes;
        bit          got;
        logic [3:0]  idx;
        logic [31:0] exp_w;
        logic [31:0] exp_ld;
        e      = model_err(st, f3, a);
        idx    = a[5:2];
        lat    = e ? 1 : (st ? ((f3 == 3'd2) ? 2 : 3) : 2);
        exp_w  = (st && !e) ? model_store(ref_mem[idx], f3, a, d) : ref_mem[idx];
        exp_ld = (!st && !e) ? model_load(ref_mem[idx], f3, a) : ref_ld;
        reads  = 0;
        writes = 0;
        got    = 0;
        @(negedge clk);
        req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (mem_read_en) reads++;
            if (mem_write_en) begin
                writes++;
                check_eq("wdata", mem_wdata, exp_w);
            end else begin
                check_eq("wdata_zero", mem_wdata, 32'd0);
            end
            check_eq("rw_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
            check_eq("mem_addr", mem_addr, {a[31:2], 2'b00});
            check_eq("busy", {31'd0, busy}, 32'd1);
            if (done) begin
                got = 1;
                check_eq("latency", c, lat);
                check_eq("err", {31'd0, err}, {31'd0, e});
                check_eq("load_data", load_data, exp_ld);
                break;
            end
            check_eq("err_low", {31'd0, err}, 32'd0);
            @(negedge clk);
            req = noisy ? 1'($urandom % 2) : 1'b0;
            if (noisy) begin
                is_store = 1'($urandom % 2); funct3 = 3'($urandom % 8);
                addr = $urandom_range(0, 63); store_data = $urandom;
            end
            @(posedge clk);
        end
        if (!got) check_eq("done_timeout", 32'd0, 32'd1);
        check_eq("reads", reads, (e || (st && f3 == 3'd2)) ? 0 : 1);
        check_eq("writes", writes, (st && !e) ? 1 : 0);
        // A request offered in the DONE cycle must not be taken.
        @(negedge clk);
        req = noisy; is_store = 1'b0; funct3 = 3'd2; addr = 32'h4; store_data = $urandom;
        @(posedge clk);
        #1;
        req = 1'b0;
        check_eq("busy_after", {31'd0, busy}, 32'd0);
        check_eq("done_after", {31'd0, done}, 32'd0);
        check_eq("err_after", {31'd0, err}, 32'd0);
        ref_mem[idx] = exp_w;
        ref_ld       = exp_ld;
        check_eq("mem_word", mem[idx], ref_mem[idx]);
        check_eq("load_hold", load_data, ref_ld);
    endtask

    initial begin
        reset = 1'b0; req = 1'b1; is_store = 1'b1; funct3 = 3'd2;
        addr = 32'h10; store_data = 32'h1234_5678;
        ref_ld = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        check_eq("rst_ld", load_data, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        req = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_after_rst", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 16; i++) txn(1'b1, 3'd2, i * 4, $urandom, 1'b0);

        txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        check_eq("lw_const", load_data, 32'hDEAD_BEEF);
        txn(1'b1, 3'd2, 32'h8, 32'h1122_3344, 1'b0);
        txn(1'b1, 3'd0, 32'hA, 32'hFF, 1'b0);
        check_eq("sb_const", mem[2], 32'h11FF_3344);
        txn(1'b0, 3'd0, 32'hA, 32'h0, 1'b0);
        check_eq("lb_const", load_data, 32'hFFFF_FFFF);
        txn(1'b0, 3'd4, 32'hA, 32'h0, 1'b0);
        check_eq("lbu_const", load_data, 32'h0000_00FF);
        txn(1'b1, 3'd2, 32'hC, 32'hAAAA_AAAA, 1'b0);
        txn(1'b1, 3'd1, 32'hE, 32'h8001, 1'b0);
        check_eq("sh_const", mem[3], 32'h8001_AAAA);
        txn(1'b0, 3'd1, 32'hE, 32'h0, 1'b0);
        check_eq("lh_const", load_data, 32'hFFFF_8001);
        txn(1'b0, 3'd5, 32'hE, 32'h0, 1'b0);
        check_eq("lhu_const", load_data, 32'h0000_8001);
        txn(1'b0, 3'd2, 32'h6, 32'h0, 1'b0);
        txn(1'b1, 3'd1, 32'h3, 32'h55, 1'b0);
        txn(1'b0, 3'd3, 32'h4, 32'h0, 1'b0);
        check_eq("err_ld_hold", load_data, 32'h0000_8001);
        txn(1'b1, 3'd0, 32'h21, 32'h5A, 1'b1);

        // Reset asserted while an SB is in its READ cycle.
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h21; store_data = 32'hC3;
        @(posedge clk);
        #1;
        check_eq("abort_read", {31'd0, mem_read_en}, 32'd1);
        req = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("abort_we", {31'd0, mem_write_en}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        ref_ld = '0;
        check_eq("abort_mem", mem[8], ref_mem[8]);
        check_eq("abort_ld", load_data, 32'd0);

        for (int i = 0; i < 150; i++)
            txn(1'($urandom % 2), 3'($urandom % 8), $urandom_range(0, 63), $urandom, 1'($urandom % 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
